// File: rtl/shr_bounce.sv
// shr_bounce: N_BIT-wide universal shift register with a built-in step prescaler.
// It supports hold, parallel load, logical shift left/right, rotate left/right,
// arithmetic shift right, and a "bounce" mode that sweeps a pattern back and
// forth and reverses at either end. It can drive an LED bar straight from the
// system clock.
//
// Ports:
//   clk      system clock, rising edge
//   rst      synchronous reset, active-high
//   en       global enable; low freezes the register, direction and prescaler
//   mode     operation select:
//              000 hold, 001 load, 010 shl, 011 shr, 100 rol, 101 ror,
//              110 bounce, 111 asr
//   sin      serial input for the logical shift modes
//   pin      parallel load data
//   div      prescaler terminal value; one step every div+1 enabled cycles
//   pout     register contents
//   sout     serial output (combinational)
//   dir      current direction, 1 = towards MSB
//   tick     one-cycle pulse while pout shows a new step result
//   edge_hit one-cycle pulse, together with tick, when bounce reversed
module shr_bounce #(
  parameter int N_BIT = 8,
  parameter int DIV_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [2:0]       mode,
  input  logic             sin,
  input  logic [N_BIT-1:0] pin,
  input  logic [DIV_W-1:0] div,
  output logic [N_BIT-1:0] pout,
  output logic             sout,
  output logic             dir,
  output logic             tick,
  output logic             edge_hit
);

  localparam logic [2:0] M_HOLD = 3'b000;
  localparam logic [2:0] M_LOAD = 3'b001;
  localparam logic [2:0] M_SHL  = 3'b010;
  localparam logic [2:0] M_SHR  = 3'b011;
  localparam logic [2:0] M_ROL  = 3'b100;
  localparam logic [2:0] M_ROR  = 3'b101;
  localparam logic [2:0] M_BNC  = 3'b110;
  localparam logic [2:0] M_ASR  = 3'b111;

  logic [N_BIT-1:0] pout_r;
  logic             dir_r;
  logic [DIV_W-1:0] cnt;
  logic             tick_r;
  logic             edge_r;

  logic             active;
  logic             step;
  logic [N_BIT-1:0] pout_nxt;
  logic             dir_nxt;
  logic             edge_nxt;

  // The prescaler only runs in modes that actually step. The >= comparison
  // lets a lowered div take effect at once, even if cnt is already past it.
  assign active = en && (mode != M_HOLD) && (mode != M_LOAD);
  assign step   = active && (cnt >= div);

  always_comb begin
    pout_nxt = pout_r;
    dir_nxt  = dir_r;
    edge_nxt = 1'b0;
    unique case (mode)
      M_SHL: begin pout_nxt = {pout_r[N_BIT-2:0], sin};           dir_nxt = 1'b1; end
      M_SHR: begin pout_nxt = {sin, pout_r[N_BIT-1:1]};           dir_nxt = 1'b0; end
      M_ROL: begin pout_nxt = {pout_r[N_BIT-2:0], pout_r[N_BIT-1]}; dir_nxt = 1'b1; end
      M_ROR: begin pout_nxt = {pout_r[0], pout_r[N_BIT-1:1]};     dir_nxt = 1'b0; end
      M_ASR: begin pout_nxt = {pout_r[N_BIT-1], pout_r[N_BIT-1:1]}; dir_nxt = 1'b0; end
      M_BNC: begin
        if (~|pout_r) begin
          // Nothing to move: value and direction stay, the step still ticks.
          pout_nxt = pout_r;
        end else if (&pout_r) begin
          // A full bar keeps its value; only the direction flips.
          dir_nxt  = ~dir_r;
          edge_nxt = 1'b1;
        end else if (dir_r && pout_r[N_BIT-1]) begin
          dir_nxt  = 1'b0;
          pout_nxt = {1'b0, pout_r[N_BIT-1:1]};
          edge_nxt = 1'b1;
        end else if (!dir_r && pout_r[0]) begin
          dir_nxt  = 1'b1;
          pout_nxt = {pout_r[N_BIT-2:0], 1'b0};
          edge_nxt = 1'b1;
        end else if (dir_r) begin
          pout_nxt = {pout_r[N_BIT-2:0], 1'b0};
        end else begin
          pout_nxt = {1'b0, pout_r[N_BIT-1:1]};
        end
      end
      default: begin
        pout_nxt = pout_r;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pout_r <= '0;
      dir_r  <= 1'b1;
      cnt    <= '0;
      tick_r <= 1'b0;
      edge_r <= 1'b0;
    end else begin
      tick_r <= 1'b0;
      edge_r <= 1'b0;
      if (en && (mode == M_LOAD)) begin
        pout_r <= pin;
        cnt    <= '0;
      end else if (step) begin
        pout_r <= pout_nxt;
        dir_r  <= dir_nxt;
        cnt    <= '0;
        tick_r <= 1'b1;
        edge_r <= edge_nxt;
      end else if (active) begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  always_comb begin
    unique case (mode)
      M_SHL, M_ROL:        sout = pout_r[N_BIT-1];
      M_SHR, M_ROR, M_ASR: sout = pout_r[0];
      default:             sout = dir_r ? pout_r[N_BIT-1] : pout_r[0];
    endcase
  end

  assign pout     = pout_r;
  assign dir      = dir_r;
  assign tick     = tick_r;
  assign edge_hit = edge_r;

endmodule

// File: tb/tb_shr_bounce.sv
module tb_shr_bounce;

  logic       clk = 1'b0;
  logic       rst, en, sin;
  logic [2:0] mode;
  logic [7:0] pin, div;
  logic [7:0] pout;
  logic       sout, dir, tick, edge_hit;

  int checks = 0;
  int errors = 0;

  shr_bounce #(.N_BIT(8), .DIV_W(8)) dut (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .sin(sin), .pin(pin), .div(div),
    .pout(pout), .sout(sout), .dir(dir), .tick(tick), .edge_hit(edge_hit)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst, en;
    logic [2:0] mode;
    logic       sin;
    logic [7:0] pin;
    logic [7:0] e_pout;
    logic       e_dir, e_tick, e_edge, e_sout;
  } vec_t;

  vec_t vecs[15];

  function automatic vec_t mk(logic r, logic e, logic [2:0] m, logic s, logic [7:0] p,
                              logic [7:0] ep, logic ed, logic et, logic ee, logic es);
    vec_t v;
    v.rst = r; v.en = e; v.mode = m; v.sin = s; v.pin = p;
    v.e_pout = ep; v.e_dir = ed; v.e_tick = et; v.e_edge = ee; v.e_sout = es;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic e, input logic [2:0] m,
                       input logic s, input logic [7:0] p, input logic [7:0] d);
    @(negedge clk);
    rst = r; en = e; mode = m; sin = s; pin = p; div = d;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Waits for the next tick; returns number of edges taken (0 on timeout).
  task automatic wait_tick(output int n);
    n = 0;
    for (int k = 1; k <= 60; k++) begin
      cyc();
      if (tick) begin
        n = k;
        break;
      end
    end
    if (n == 0) check("tick_timeout", 0, 1);
  endtask

  initial begin
    int n;
    int edges;
    logic [7:0] walk[15];

    rst = 1'b1; en = 1'b1; mode = 3'b110; sin = 1'b0; pin = 8'h00; div = 8'h00;

    vecs[0]  = mk(1, 1, 3'b110, 0, 8'h00, 8'h00, 1, 0, 0, 0);
    vecs[1]  = mk(1, 1, 3'b110, 0, 8'h00, 8'h00, 1, 0, 0, 0);
    vecs[2]  = mk(0, 1, 3'b001, 0, 8'h81, 8'h81, 1, 0, 0, 1);
    vecs[3]  = mk(0, 1, 3'b010, 1, 8'h00, 8'h03, 1, 1, 0, 0);
    vecs[4]  = mk(0, 1, 3'b010, 1, 8'h00, 8'h07, 1, 1, 0, 0);
    vecs[5]  = mk(0, 1, 3'b001, 0, 8'h81, 8'h81, 1, 0, 0, 1);
    vecs[6]  = mk(0, 1, 3'b101, 0, 8'h00, 8'hC0, 0, 1, 0, 0);
    vecs[7]  = mk(0, 1, 3'b001, 0, 8'h90, 8'h90, 0, 0, 0, 0);
    vecs[8]  = mk(0, 1, 3'b111, 1, 8'h00, 8'hC8, 0, 1, 0, 0);
    vecs[9]  = mk(0, 1, 3'b111, 1, 8'h00, 8'hE4, 0, 1, 0, 0);
    vecs[10] = mk(0, 1, 3'b100, 0, 8'h00, 8'hC9, 1, 1, 0, 1);
    vecs[11] = mk(0, 1, 3'b011, 0, 8'h00, 8'h64, 0, 1, 0, 0);
    vecs[12] = mk(0, 1, 3'b000, 1, 8'hFF, 8'h64, 0, 0, 0, 0);
    vecs[13] = mk(0, 0, 3'b010, 1, 8'hFF, 8'h64, 0, 0, 0, 0);
    vecs[14] = mk(1, 1, 3'b001, 0, 8'hFF, 8'h00, 1, 0, 0, 0);

    for (int i = 0; i < 15; i++) begin
      drive(vecs[i].rst, vecs[i].en, vecs[i].mode, vecs[i].sin, vecs[i].pin, 8'h00);
      cyc();
      check($sformatf("v%0d_pout", i), pout, vecs[i].e_pout);
      check($sformatf("v%0d_dir", i), dir, vecs[i].e_dir);
      check($sformatf("v%0d_tick", i), tick, vecs[i].e_tick);
      check($sformatf("v%0d_edge", i), edge_hit, vecs[i].e_edge);
      check($sformatf("v%0d_sout", i), sout, vecs[i].e_sout);
    end

    // sout before the first shift step shows the MSB of the loaded value
    drive(0, 1, 3'b001, 0, 8'h81, 8'h00);
    cyc();
    drive(0, 1, 3'b010, 1, 8'h00, 8'h00);
    #1;
    check("sout_pre_shl", sout, 1);
    cyc();
    check("shl_after", pout, 8'h03);

    // Bounce walk from 0x01
    walk = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h40,
             8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h02};
    drive(1, 1, 3'b110, 0, 8'h00, 8'h00);
    cyc();
    drive(0, 1, 3'b001, 0, 8'h01, 8'h00);
    cyc();
    drive(0, 1, 3'b110, 0, 8'h00, 8'h00);
    edges = 0;
    for (int i = 0; i < 15; i++) begin
      cyc();
      check($sformatf("bnc%0d_pout", i), pout, walk[i]);
      check($sformatf("bnc%0d_tick", i), tick, 1);
      check($sformatf("bnc%0d_edge", i), edge_hit, (i == 7 || i == 14) ? 1 : 0);
      if (i >= 1 && edge_hit) edges++;
      if (i == 7) check("bnc_dir_after_top", dir, 0);
    end
    check("bnc_period_edges", edges, 2);

    // Prescaler div=3: tick every 4 cycles, en low 5 cycles stretches to 9
    drive(0, 1, 3'b110, 0, 8'h00, 8'h03);
    wait_tick(n);
    wait_tick(n);
    check("div3_interval", n, 4);
    n = 0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      en = (k >= 3 && k <= 7) ? 1'b0 : 1'b1;
      cyc();
      if (tick) begin
        n = k;
        break;
      end
    end
    check("div3_en_gap_interval", n, 9);
    en = 1'b1;

    // Lowering div from 7 to 2 while cnt=5 steps at the next edge
    drive(0, 1, 3'b001, 0, 8'h01, 8'h07);
    cyc();
    drive(0, 1, 3'b110, 0, 8'h00, 8'h07);
    n = 0;
    for (int k = 0; k < 5; k++) begin
      cyc();
      if (tick) n++;
    end
    check("div7_no_tick_yet", n, 0);
    drive(0, 1, 3'b110, 0, 8'h00, 8'h02);
    cyc();
    check("div_lowered_tick", tick, 1);
    check("div_lowered_pout", pout, 8'h02);

    // Bounce with all-zero register
    drive(1, 1, 3'b110, 0, 8'h00, 8'h00);
    cyc();
    drive(0, 1, 3'b110, 0, 8'h00, 8'h00);
    for (int i = 0; i < 3; i++) begin
      cyc();
      check($sformatf("zero%0d_pout", i), pout, 8'h00);
      check($sformatf("zero%0d_tick", i), tick, 1);
      check($sformatf("zero%0d_edge", i), edge_hit, 0);
      check($sformatf("zero%0d_dir", i), dir, 1);
    end

    // Bounce with all-ones register
    drive(0, 1, 3'b001, 0, 8'hFF, 8'h00);
    cyc();
    drive(0, 1, 3'b110, 0, 8'h00, 8'h00);
    for (int i = 0; i < 4; i++) begin
      cyc();
      check($sformatf("ones%0d_pout", i), pout, 8'hFF);
      check($sformatf("ones%0d_edge", i), edge_hit, 1);
      check($sformatf("ones%0d_dir", i), dir, (i % 2 == 0) ? 0 : 1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
